ahb_rom_arbiter: RTL and testbench



---
 rtl/ahb_rom_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/ahb_rom_arbiter.sv | 118 +++++++++++
 tb/tb_ahb_rom_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_rom_pkg.sv
// Shared types and helpers for the instruction-ROM arbiter.
package ahb_rom_pkg;

    localparam int unsigned ROM_DEPTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic rid_t;

    // A byte address is legal when word aligned and inside the ROM.
    // Addresses are zero-extended to 64 bits so any ADDR_W up to 64 fits.
    function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr[63:2] < 62'(depth));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
module rr_arb2
    import ahb_rom_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  rid_t last_gnt,
    output rid_t gnt_id,
    output logic gnt_vld
);

    // When both request, the one not granted last wins.
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = 1'b0;
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_rom_arbiter.sv
// Two-requester arbiter and sequencer for the 1-cycle registered instruction ROM.
module ahb_rom_arbiter
    import ahb_rom_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              ack0_o,
    output logic              err0_o,
    output logic              ack1_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              sel_0,
    output logic              rd_en_rom,
    output logic [ADDR_W-1:0] address_rom,
    input  logic [DATA_W-1:0] instr
);

    state_t            state;
    rid_t              gnt_id;
    rid_t              last_gnt;
    rid_t              pick_id;
    logic              pick_vld;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_legal;

    rr_arb2 u_arb (
        .req0    (req0_i),
        .req1    (req1_i),
        .last_gnt(last_gnt),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    assign pick_addr  = pick_id ? addr1_i : addr0_i;
    assign pick_legal = addr_legal(64'(pick_addr), ROM_DEPTH);

    // Sequencer FSM; every output is a flop so the ROM and masters see clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt_id      <= 1'b0;
            last_gnt    <= 1'b1;   // requester 0 wins the first contest
            ack0_o      <= 1'b0;
            err0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            err1_o      <= 1'b0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            sel_0       <= 1'b0;
            rd_en_rom   <= 1'b0;
            address_rom <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_id <= pick_id;
                        busy_o <= 1'b1;
                        if (pick_legal) begin
                            state       <= ISSUE;
                            sel_0       <= 1'b1;
                            rd_en_rom   <= 1'b1;
                            address_rom <= ADDR_W'(pick_addr[4:2]);
                        end else begin
                            // Bad address: skip the ROM and answer with an error pulse next cycle.
                            state   <= DONE;
                            rdata_o <= '0;
                            if (pick_id) begin
                                ack1_o <= 1'b1;
                                err1_o <= 1'b1;
                            end else begin
                                ack0_o <= 1'b1;
                                err0_o <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    // ROM samples select/enable at the end of this cycle.
                    state       <= CAPTURE;
                    sel_0       <= 1'b0;
                    rd_en_rom   <= 1'b0;
                    address_rom <= '0;
                end
                CAPTURE: begin
                    state   <= DONE;
                    rdata_o <= instr;
                    if (gnt_id) begin
                        ack1_o <= 1'b1;
                    end else begin
                        ack0_o <= 1'b1;
                    end
                end
                DONE: begin
                    // Requests are ignored here; the pointer moves even on errors.
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    last_gnt <= gnt_id;
                    ack0_o   <= 1'b0;
                    err0_o   <= 1'b0;
                    ack1_o   <= 1'b0;
                    err1_o   <= 1'b0;
                    rdata_o  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Self-checking bench for ahb_rom_arbiter with a behavioural ROM and scoreboards.
module tb_ahb_rom_arbiter;

    localparam int ROM_DEPTH = 5;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic              ack0_o, err0_o, ack1_o, err1_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o, sel_0, rd_en_rom;
    logic [ADDR_W-1:0] address_rom;
    logic [DATA_W-1:0] instr = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ahb_rom_arbiter #(.ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_i     (req0),
        .addr0_i    (addr0),
        .req1_i     (req1),
        .addr1_i    (addr1),
        .ack0_o     (ack0_o),
        .err0_o     (err0_o),
        .ack1_o     (ack1_o),
        .err1_o     (err1_o),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .sel_0      (sel_0),
        .rd_en_rom  (rd_en_rom),
        .address_rom(address_rom),
        .instr      (instr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [2:0] i);
        case (i)
            3'd0:    return 32'hAAAA_AAAA;
            3'd1:    return 32'hBBBB_BBBB;
            3'd2:    return 32'hCCCC_CCCC;
            3'd3:    return 32'hDDDD_DDDD;
            3'd4:    return 32'hEEEE_EEEE;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Behavioural ROM: registered read, sampled when selected and enabled.
    always @(posedge clk) begin
        if (sel_0 && rd_en_rom) instr <= rom_word(address_rom[2:0]);
    end

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int       cyc;
        logic [2:0] idx;
    } iss_t;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        int          n0;
        int          n1;
    } vec_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    logic mptr = 1'b1;   // last granted id in the reference model

    function automatic logic legal(input logic [31:0] a);
        return ((a & 32'h3) == 32'h0) && (a < 32'(4 * ROM_DEPTH));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic id, input logic [31:0] a, input int s);
        if (legal(a)) begin
            exp_q.push_back('{id, 1'b0, rom_word(a[4:2]), s + 3});
            iss_q.push_back('{s + 1, a[4:2]});
        end else begin
            exp_q.push_back('{id, 1'b1, 32'h0, s + 1});
        end
    endtask

    // Drive one held-request pattern; requesters drop req after their last ack.
    task automatic run_row(input vec_t v);
        int   s, rem0, rem1, r0d, r1d, waited, budget;
        logic id;
        logic [31:0] a;
        s = cyc;
        rem0 = v.n0;
        rem1 = v.n1;
        while (rem0 > 0 || rem1 > 0) begin
            if (rem0 > 0 && rem1 > 0) id = ~mptr;
            else id = (rem0 > 0) ? 1'b0 : 1'b1;
            a = id ? v.a1 : v.a0;
            push_txn(id, a, s);
            s += legal(a) ? 4 : 2;
            mptr = id;
            if (id) rem1--; else rem0--;
        end
        r0d = v.n0;
        r1d = v.n1;
        addr0 = v.a0;
        addr1 = v.a1;
        req0 = (r0d > 0);
        req1 = (r1d > 0);
        waited = 0;
        budget = 8 * (v.n0 + v.n1) + 8;
        while ((r0d > 0 || r1d > 0) && waited < budget) begin
            @(negedge clk);
            if (ack0_o && r0d > 0) r0d--;
            if (ack1_o && r1d > 0) r1d--;
            @(posedge clk);
            #1;
            req0 = (r0d > 0);
            req1 = (r1d > 0);
            waited++;
        end
        if (r0d > 0 || r1d > 0) begin
            checks++;
            errors++;
            $display("FAIL row_timeout got=%0d/%0d acks outstanding exp=0", r0d, r1d);
            req0 = 1'b0;
            req1 = 1'b0;
            exp_q.delete();
            iss_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack and every ROM access is matched against the scoreboards.
    exp_t e;
    iss_t is;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if ((err0_o && !ack0_o) || (err1_o && !ack1_o)) begin
                    checks++;
                    errors++;
                    $display("FAIL err_without_ack got=%b%b%b%b exp=ack with err", ack0_o, err0_o, ack1_o, err1_o);
                end
                if (ack0_o || ack1_o) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack got=ack0 %b ack1 %b exp=none (cycle %0d)", ack0_o, ack1_o, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if ((ack0_o && ack1_o) || (ack1_o != e.id) ||
                            ((ack1_o ? err1_o : err0_o) != e.err) ||
                            (rdata_o != e.data) || (cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL ack_txn got=ack0 %b ack1 %b err %b%b data %h cyc %0d exp=id %0d err %b data %h cyc %0d",
                                     ack0_o, ack1_o, err0_o, err1_o, rdata_o, cyc, e.id, e.err, e.data, e.cyc);
                        end
                    end
                end else begin
                    chk("rdata_idle_zero", rdata_o, 32'h0);
                end
                if (sel_0 || rd_en_rom) begin
                    checks++;
                    if (iss_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rom_access got=sel %b rd_en %b exp=none (cycle %0d)", sel_0, rd_en_rom, cyc);
                    end else begin
                        is = iss_q.pop_front();
                        if (!(sel_0 && rd_en_rom) || (address_rom != {29'b0, is.idx}) || (cyc != is.cyc)) begin
                            errors++;
                            $display("FAIL rom_access got=sel %b rd_en %b addr %h cyc %0d exp=1 1 addr %h cyc %0d",
                                     sel_0, rd_en_rom, address_rom, cyc, is.idx, is.cyc);
                        end
                    end
                end
            end
        end
    end

    vec_t vt[7];
    logic busy_pat[9];

    initial begin
        vt[0] = '{32'h0000_0000, 32'h0000_0000, 1, 0};
        vt[1] = '{32'h0000_0004, 32'h0000_0008, 2, 2};
        vt[2] = '{32'h0000_0000, 32'h0000_0014, 0, 1};
        vt[3] = '{32'h0000_0006, 32'h0000_0000, 1, 0};
        vt[4] = '{32'h0000_0003, 32'h0000_0100, 2, 2};
        vt[5] = '{32'h0000_0010, 32'h0000_0013, 1, 1};
        vt[6] = '{32'h0000_000C, 32'h8000_0000, 1, 1};
        busy_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(ack0_o), 32'h0);
        chk("rst_err0", 32'(err0_o), 32'h0);
        chk("rst_ack1", 32'(ack1_o), 32'h0);
        chk("rst_err1", 32'(err1_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_sel", 32'(sel_0), 32'h0);
        chk("rst_rd_en", 32'(rd_en_rom), 32'h0);
        chk("rst_address", address_rom, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_row(vt[i]);

        // Reset during CAPTURE aborts the read without an ack
        begin
            int s;
            s = cyc;
            req0 = 1'b1;
            addr0 = 32'h0;
            iss_q.push_back('{s + 1, 3'd0});
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("abort_busy_before", 32'(busy_o), 32'h1);
            reset_n = 1'b0;
            #1;
            chk("abort_busy_async", 32'(busy_o), 32'h0);
            chk("abort_acks_async", {28'h0, ack0_o, err0_o, ack1_o, err1_o}, 32'h0);
            req0 = 1'b0;
            mptr = 1'b1;
            repeat (2) @(negedge clk);
            chk("abort_no_ack_in_reset", {28'h0, ack0_o, err0_o, ack1_o, err1_o}, 32'h0);
            reset_n = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            run_row('{32'h0000_0010, 32'h0, 1, 0});
        end

        // req1 alone, req0 arrives while busy: served right after one IDLE cycle
        begin
            int s;
            s = cyc;
            req1 = 1'b1;
            addr1 = 32'h8;
            addr0 = 32'h4;
            push_txn(1'b1, 32'h8, s);
            push_txn(1'b0, 32'h4, s + 4);
            mptr = 1'b0;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                chk($sformatf("busy_seq_%0d", k), 32'(busy_o), 32'(busy_pat[k]));
                @(posedge clk);
                #1;
                if (k == 0) req0 = 1'b1;
                if (k == 3) req1 = 1'b0;
                if (k == 7) req0 = 1'b0;
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("rom_queue_empty", 32'(iss_q.size()), 32'h0);
        chk("final_busy", 32'(busy_o), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
